// File: rtl/cim_host_seq.sv
// Host-side sequencer for the CIM core: gathers six activation beats, fires one
// job, waits for an armed completion or timeout, then presents the result.
module cim_host_seq #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  cfg_inwidth,
    input  logic                  cfg_wwidth,
    input  logic                  cfg_cima,
    output logic                  cim_start,
    output logic                  cim_inwidth,
    output logic                  cim_wwidth,
    output logic                  cim_cima,
    output logic [6*WORD_W-1:0]   cim_xin0,
    input  logic                  cim_st,
    input  logic [50:0]           cim_nout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [50:0]           m_data,
    output logic                  m_err,
    output logic                  busy,
    output logic [15:0]           job_cnt
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       beat_q;
    logic             arm_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic s_hs;
    logic done;
    logic tmo;

    assign s_hs = s_valid && s_ready;
    // Completion only counts once st has been seen low in this WAIT, so a
    // level left high by the previous job cannot end the new one.
    assign done = arm_q && cim_st;
    assign tmo  = (wait_cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (s_hs && beat_q == 3'd5) state_d = ST_FIRE;
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: if (done || tmo) state_d = ST_OUT;
            ST_OUT:  if (m_ready) state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // Handshake-facing outputs are gated by rst so nothing is offered or
    // started during the reset cycle itself.
    always_comb begin
        s_ready   = !rst && (state_q == ST_LOAD);
        cim_start = !rst && (state_q == ST_FIRE);
        m_valid   = !rst && (state_q == ST_OUT);
        busy      = !rst && !((state_q == ST_LOAD) && (beat_q == 3'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            arm_q       <= 1'b0;
            wait_cnt_q  <= '0;
            cim_xin0    <= '0;
            cim_inwidth <= 1'b0;
            cim_wwidth  <= 1'b0;
            cim_cima    <= 1'b0;
            m_data      <= '0;
            m_err       <= 1'b0;
            job_cnt     <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (s_hs) begin
                        for (int unsigned k = 0; k < 6; k++) begin
                            if (beat_q == 3'(k)) begin
                                cim_xin0[k*WORD_W +: WORD_W] <= s_data;
                            end
                        end
                        if (beat_q == 3'd0) begin
                            cim_inwidth <= cfg_inwidth;
                            cim_wwidth  <= cfg_wwidth;
                            cim_cima    <= cfg_cima;
                        end
                        beat_q <= (beat_q == 3'd5) ? 3'd0 : beat_q + 3'd1;
                    end
                end
                ST_FIRE: begin
                    arm_q      <= 1'b0;
                    wait_cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (!cim_st) begin
                        arm_q <= 1'b1;
                    end
                    if (!tmo) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (done) begin
                        m_data <= cim_nout;
                        m_err  <= 1'b0;
                    end else if (tmo) begin
                        m_data <= '0;
                        m_err  <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        job_cnt <= job_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_host_seq.sv
// Directed bench for cim_host_seq: load/fire/wait/out flow, stale-st rejection,
// timeout, output back-pressure, mid-load reset and job counter wrap.
module tb_cim_host_seq;

    localparam int unsigned TIMEOUT = 1023;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         cfg_inwidth, cfg_wwidth, cfg_cima;
    logic         cim_start;
    logic         cim_inwidth, cim_wwidth, cim_cima;
    logic [191:0] cim_xin0;
    logic         cim_st;
    logic [50:0]  cim_nout;
    logic         m_valid;
    logic         m_ready;
    logic [50:0]  m_data;
    logic         m_err;
    logic         busy;
    logic [15:0]  job_cnt;

    int checks = 0;
    int errors = 0;

    cim_host_seq #(.WORD_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_inwidth(cfg_inwidth), .cfg_wwidth(cfg_wwidth), .cfg_cima(cfg_cima),
        .cim_start(cim_start), .cim_inwidth(cim_inwidth), .cim_wwidth(cim_wwidth),
        .cim_cima(cim_cima), .cim_xin0(cim_xin0), .cim_st(cim_st), .cim_nout(cim_nout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
        .busy(busy), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] exp_xin(input logic [31:0] base);
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    // Six back-to-back beats base..base+5; only beat 0 carries the real cfg.
    task automatic load6(input logic [31:0] base, input logic [2:0] cfg);
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(k);
            {cfg_inwidth, cfg_wwidth, cfg_cima} = (k == 0) ? cfg : ~cfg;
            tick();
        end
        s_valid = 1'b0;
        s_data  = '0;
        {cfg_inwidth, cfg_wwidth, cfg_cima} = 3'b000;
    endtask

    initial begin
        int starts;
        int bad;
        int n;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        cfg_inwidth = 1'b0; cfg_wwidth = 1'b0; cfg_cima = 1'b0;
        cim_st = 1'b0; cim_nout = '0;
        tick();
        tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_cim_start", cim_start, 0);
        check("rst_job_cnt", job_cnt, 0);
        check("rst_xin", cim_xin0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_busy", busy, 0);

        // Basic job with 10-cycle core latency and 20 cycles of back-pressure.
        cim_nout = 51'h1_2345_6789_ABCD;
        load6(32'h0000_0001, 3'b110);
        check("s1_start", cim_start, 1);
        check("s1_fire_s_ready", s_ready, 0);
        check("s1_busy", busy, 1);
        check("s1_xin", cim_xin0, 192'h00000006_00000005_00000004_00000003_00000002_00000001);
        check("s1_cfg", {cim_inwidth, cim_wwidth, cim_cima}, 3'b110);
        starts = 0;
        repeat (10) begin
            tick();
            starts += int'(cim_start);
        end
        cim_st = 1'b1;
        tick();
        check("s1_extra_starts", starts, 0);
        check("s1_m_valid", m_valid, 1);
        check("s1_m_data", m_data, 51'h1_2345_6789_ABCD);
        check("s1_m_err", m_err, 0);
        check("s1_job_cnt_pre", job_cnt, 0);
        bad = 0;
        repeat (20) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== 51'h1_2345_6789_ABCD || m_err !== 1'b0 ||
                s_ready !== 1'b0 || cim_start !== 1'b0) bad++;
        end
        check("s1_out_hold", bad, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s1_m_valid_done", m_valid, 0);
        check("s1_job_cnt", job_cnt, 1);
        check("s1_back_to_load", s_ready, 1);
        check("s1_idle_busy", busy, 0);

        // Stale st high across FIRE: must wait for low then a fresh rise.
        cim_nout = 51'h7_0000_0000_0042;
        load6(32'h0000_0010, 3'b101);
        check("s2_xin", cim_xin0, exp_xin(32'h0000_0010));
        check("s2_cfg", {cim_inwidth, cim_wwidth, cim_cima}, 3'b101);
        bad = 0;
        repeat (3) begin
            tick();
            if (m_valid !== 1'b0) bad++;
        end
        cim_st = 1'b0;
        repeat (5) begin
            tick();
            if (m_valid !== 1'b0) bad++;
        end
        check("s2_stale_ignored", bad, 0);
        cim_st = 1'b1;
        tick();
        check("s2_m_valid", m_valid, 1);
        check("s2_m_data", m_data, 51'h7_0000_0000_0042);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s2_job_cnt", job_cnt, 2);
        bad = 0;
        repeat (4) begin
            tick();
            if (m_valid !== 1'b0 || cim_start !== 1'b0) bad++;
        end
        check("s2_single_completion", bad, 0);

        // Timeout: st never rises.
        cim_st = 1'b0;
        load6(32'h0000_0100, 3'b001);
        tick();
        n = 0;
        while (m_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("s3_tmo_cycles", n, TIMEOUT + 1);
        check("s3_m_err", m_err, 1);
        check("s3_m_data", m_data, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s3_job_cnt", job_cnt, 3);

        // Completion in the same cycle the counter reaches TIMEOUT wins.
        cim_nout = 51'h0_0BAD_CAFE_0001;
        load6(32'h0000_0200, 3'b011);
        tick();
        repeat (TIMEOUT) tick();
        check("s3b_not_yet", m_valid, 0);
        cim_st = 1'b1;
        tick();
        check("s3b_m_valid", m_valid, 1);
        check("s3b_m_err", m_err, 0);
        check("s3b_m_data", m_data, 51'h0_0BAD_CAFE_0001);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        cim_st = 1'b0;

        // Reset after three beats discards the partial job.
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hAAAA_0000 + 32'(k);
            {cfg_inwidth, cfg_wwidth, cfg_cima} = 3'b111;
            tick();
        end
        s_valid = 1'b0;
        check("s5_partial_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("s5_rst_s_ready", s_ready, 0);
        check("s5_rst_xin", cim_xin0, 0);
        check("s5_rst_job_cnt", job_cnt, 0);
        rst = 1'b0;
        tick();
        check("s5_no_start", cim_start, 0);
        check("s5_idle_busy", busy, 0);
        cim_nout = 51'h2_2222_3333_4444;
        load6(32'h5555_0000, 3'b010);
        check("s5_start", cim_start, 1);
        check("s5_xin", cim_xin0, exp_xin(32'h5555_0000));
        check("s5_cfg", {cim_inwidth, cim_wwidth, cim_cima}, 3'b010);
        repeat (2) tick();
        cim_st = 1'b1;
        tick();
        check("s5_m_data", m_data, 51'h2_2222_3333_4444);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s5_job_cnt", job_cnt, 1);

        // Job counter wrap from 0xFFFF.
        cim_st = 1'b0;
        force dut.job_cnt = 16'hFFFF;
        #1;
        release dut.job_cnt;
        #1;
        check("s6_preload", job_cnt, 16'hFFFF);
        load6(32'h0000_0300, 3'b100);
        repeat (2) tick();
        cim_st = 1'b1;
        tick();
        check("s6_m_valid", m_valid, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s6_wrap", job_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_host_seq.md
CIM_HOST_SEQ -- requirements
Module: cim_host_seq

Interface
REQ-001 Parameter: WORD_W, 32, width of the activation input stream word; fixed so that 6 beats fill 192 bits.
REQ-002 Parameter: TIMEOUT, 1023, maximum WAIT cycles before a job is aborted.
REQ-003 Port: clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: s_valid  in  1  activation word valid.
REQ-006 Port: s_ready  out  1  activation word accepted when s_valid&s_ready.
REQ-007 Port: s_data  in  32  activation word.
REQ-008 Port: cfg_inwidth, cfg_wwidth, cfg_cima  in  1 each  job configuration, sampled with beat 0.
REQ-009 Port: cim_start  out  1  start pulse to the CIM core.
REQ-010 Port: cim_inwidth, cim_wwidth, cim_cima  out  1 each  registered job configuration to the core.
REQ-011 Port: cim_xin0  out  192  registered activation vector to the core.
REQ-012 Port: cim_st  in  1  core completion flag.
REQ-013 Port: cim_nout  in  51  core accumulated result.
REQ-014 Port: m_valid  out  1  result valid.
REQ-015 Port: m_ready  in  1  result consumer ready.
REQ-016 Port: m_data  out  51  captured result.
REQ-017 Port: m_err  out  1  result is a timeout abort, qualified by m_valid.
REQ-018 Port: busy  out  1  high in every state except LOAD with beat count 0.
REQ-019 Port: job_cnt  out  16  completed jobs (normal or timeout); wraps 0xFFFF->0x0000.

Function
REQ-020 States SHALL be LOAD, FIRE, WAIT, OUT; no other reachable states.
REQ-021 LOAD: s_ready=1; beat k (k=0..5) SHALL be written to cim_xin0[32k+31:32k] on handshake; the beat counter increments per handshake only.
REQ-022 On the beat-0 handshake, cfg_* SHALL be registered into cim_inwidth/cim_wwidth/cim_cima.
REQ-023 On the beat-5 handshake the next state SHALL be FIRE and the beat counter SHALL clear to 0.
REQ-024 FIRE lasts exactly 1 cycle with cim_start=1, then WAIT; cim_start is 0 in every other state.
REQ-025 cim_xin0 and cim_* config SHALL remain stable from FIRE until the next LOAD handshake.
REQ-026 WAIT: an arm flag clears on entry and sets on the first cycle with cim_st=0; completion is the first cycle with cim_st=1 while armed, so a stale high st from the prior job is never accepted.
REQ-027 On completion, m_data<=cim_nout and m_err<=0, then OUT.
REQ-028 WAIT cycle counter starts at 0 on entry; if it reaches TIMEOUT without completion, m_data<=0 and m_err<=1, then OUT; completion and timeout in the same cycle SHALL resolve as completion.
REQ-029 OUT: m_valid=1, with m_data and m_err held stable until m_valid&m_ready; then LOAD and job_cnt increments.
REQ-030 Latency: last beat accepted in cycle N -> cim_start high in N+1; armed completion sampled in cycle M -> m_valid high in M+1.
REQ-031 s_ready SHALL be 0 in FIRE, WAIT and OUT; no input is buffered there.

Reset
REQ-032 While rst=1, the next state SHALL be LOAD with beat counter 0, arm=0, WAIT counter 0, and all outputs 0 (s_ready, cim_*, m_*, busy, job_cnt).
REQ-033 First cycle after rst deasserts: s_ready=1, busy=0.
REQ-034 Reset in any state SHALL discard partial beats and in-flight results, and no cim_start may follow.

Verification
REQ-035 Scenario: 6 beats 0x00000001..0x00000006, no stalls, cim_st rises 10 cycles after start with nout=0x1_2345_6789_ABCD -> cim_xin0=0x...00000006_..._00000001, one start pulse, m_data=0x1_2345_6789_ABCD, m_err=0, job_cnt=1.
REQ-036 Scenario: cim_st held high across FIRE into WAIT, drops after 3 cycles, rises after 5 more -> exactly one completion, taken only on the second rise.
REQ-037 Scenario: cim_st never rises -> m_valid exactly TIMEOUT+1 cycles after WAIT entry, m_err=1, m_data=0.
REQ-038 Scenario: m_ready low 20 cycles in OUT -> m_data stable, s_ready=0 throughout, cim_start=0; handshake -> LOAD and job_cnt+1.
REQ-039 Scenario: rst after 3 beats, then 6 fresh beats -> only fresh beats appear in cim_xin0, cfg taken from the fresh beat 0.
REQ-040 Scenario: preload job_cnt to 0xFFFF via 65535 jobs (or force) then complete one job -> job_cnt=0x0000.
